// File: rtl/ssd_pkg.sv
// ---------------------------------------------------------------------------
// ssd_pkg
// Shared types and helpers for the 4-digit seven-segment scan controller.
//   slot_t        : 2-bit digit slot index (mux select)
//   digit_t       : one BCD digit
//   scan_state_t  : scan FSM states
//   anode_onehot  : per-slot anode pattern honouring the anode polarity
//   lz_blanked    : leading-zero rule for one slot of a packed digit word
// ---------------------------------------------------------------------------
package ssd_pkg;

   localparam int NUM_DIGITS = 4;

   typedef logic [1:0] slot_t;
   typedef logic [3:0] digit_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      DRIVE = 2'd2
   } scan_state_t;

   // One-hot anode enable for a slot, inverted for common-anode (active-low) parts.
   function automatic logic [NUM_DIGITS-1:0] anode_onehot(input slot_t slot,
                                                          input logic active_low);
      logic [NUM_DIGITS-1:0] onehot;
      onehot = 4'b0001 << slot;
      if (active_low) begin
         anode_onehot = ~onehot;
      end else begin
         anode_onehot = onehot;
      end
   endfunction

   // A slot is a leading zero when it and every more-significant digit are 0.
   // The ones digit is never blanked so a value of zero still shows "0".
   function automatic logic lz_blanked(input slot_t slot,
                                       input logic [4*NUM_DIGITS-1:0] digits);
      digit_t d3;
      digit_t d2;
      digit_t d1;
      d3 = digits[15:12];
      d2 = digits[11:8];
      d1 = digits[7:4];
      case (slot)
         2'd3:    lz_blanked = (d3 == 4'd0);
         2'd2:    lz_blanked = (d3 == 4'd0) && (d2 == 4'd0);
         2'd1:    lz_blanked = (d3 == 4'd0) && (d2 == 4'd0) && (d1 == 4'd0);
         default: lz_blanked = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ssd_prescaler.sv
// ---------------------------------------------------------------------------
// ssd_prescaler
// Terminal-count divider: counts 0..DIV-1 and wraps.
//   clk    : system clock
//   reset  : synchronous active-high reset (count -> 0)
//   clear  : synchronous clear, holds count at 0 while asserted
//   enable : advance the count
//   count  : current count, W bits
//   tc     : terminal count, high while count == DIV-1
// ---------------------------------------------------------------------------
module ssd_prescaler #(
   parameter int DIV = 100000,
   parameter int W   = $clog2(DIV)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         enable,
   output logic [W-1:0] count,
   output logic         tc
);

   localparam logic [W-1:0] LAST = W'(DIV - 1);
   localparam logic [W-1:0] ZERO = W'(0);
   localparam logic [W-1:0] ONE  = W'(1);

   // Terminal count is decoded from the registered count.
   assign tc = (count == LAST);

   // Divider counter with clear priority over counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= ZERO;
      end else if (clear) begin
         count <= ZERO;
      end else if (enable) begin
         if (tc) begin
            count <= ZERO;
         end else begin
            count <= count + ONE;
         end
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/ssd_scan_controller.sv
// ---------------------------------------------------------------------------
// ssd_scan_controller
// Time-multiplexing scheduler for a 4-digit seven-segment display. Each slot
// lasts REFRESH_DIV cycles; the first BLANK_CYCLES of a slot keep every
// anode off to hide ghosting while the external digit mux switches. New
// digits are double-buffered and only commit at a frame wrap (or in IDLE).
//   clk           : system clock
//   reset         : synchronous active-high reset
//   enable        : 1 scans, 0 blanks the display (FSM to IDLE)
//   lz_suppress   : 1 blanks leading zeros
//   load          : one-cycle strobe capturing digits_in
//   digits_in     : {d3,d2,d1,d0}, d0 = ones
//   digits_out    : committed digits for the external mux
//   refresh_count : current slot / mux select
//   anode         : per-digit enable, bit i drives digit i
//   blank         : 1 while all anodes are inactive
//   pending       : shadow holds an uncommitted load
//   frame_done    : one-cycle pulse after the last cycle of slot 3
// All outputs are registered; anode/blank follow the FSM with 1 clk latency
// relative to the condition that moves the FSM, i.e. they line up with the
// registered state and refresh_count.
// ---------------------------------------------------------------------------
module ssd_scan_controller
   import ssd_pkg::*;
#(
   parameter int REFRESH_DIV      = 100000,
   parameter int BLANK_CYCLES     = 1000,
   parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        lz_suppress,
   input  logic        load,
   input  logic [15:0] digits_in,
   output logic [15:0] digits_out,
   output logic [1:0]  refresh_count,
   output logic [3:0]  anode,
   output logic        blank,
   output logic        pending,
   output logic        frame_done
);

   localparam int PW = $clog2(REFRESH_DIV);

   // Last prescaler value spent in BLANK; unused when there is no blanking.
   localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES > 0) ? (BLANK_CYCLES - 1) : 0);

   // State every slot starts in: with no blanking interval slots open in DRIVE.
   localparam scan_state_t SLOT_ENTRY = (BLANK_CYCLES > 0) ? BLANK : DRIVE;

   localparam logic [3:0] ANODE_OFF = ANODE_ACTIVE_LOW ? 4'b1111 : 4'b0000;

   scan_state_t   state_r;
   scan_state_t   next_state_s;
   slot_t         next_slot_s;
   logic [15:0]   shadow_r;
   logic [15:0]   next_digits_s;
   logic [15:0]   next_shadow_s;
   logic          next_pending_s;
   logic          frame_wrap_s;
   logic          commit_now_s;
   logic          drive_s;
   logic [3:0]    next_anode_s;
   logic          pre_clear_s;
   logic [PW-1:0] pre_count_s;
   logic          pre_tc_s;

   // The slot timer restarts whenever the display is idle or being disabled.
   assign pre_clear_s = !enable || (state_r == IDLE);

   ssd_prescaler #(
      .DIV (REFRESH_DIV),
      .W   (PW)
   ) u_prescaler (
      .clk    (clk),
      .reset  (reset),
      .clear  (pre_clear_s),
      .enable (1'b1),
      .count  (pre_count_s),
      .tc     (pre_tc_s)
   );

   // Scan FSM next-state and next slot.
   always_comb begin
      next_state_s = state_r;
      next_slot_s  = refresh_count;
      if (!enable) begin
         next_state_s = IDLE;
         next_slot_s  = 2'd0;
      end else begin
         case (state_r)
            IDLE: begin
               next_state_s = SLOT_ENTRY;
               next_slot_s  = 2'd0;
            end
            BLANK: begin
               if (pre_count_s == BLANK_LAST) begin
                  next_state_s = DRIVE;
               end else begin
                  next_state_s = BLANK;
               end
            end
            DRIVE: begin
               if (pre_tc_s) begin
                  next_state_s = SLOT_ENTRY;
                  next_slot_s  = refresh_count + 2'd1;
               end else begin
                  next_state_s = DRIVE;
               end
            end
            default: begin
               next_state_s = IDLE;
               next_slot_s  = 2'd0;
            end
         endcase
      end
   end

   // Double buffer: digits commit at the frame wrap, or at once while idle.
   // A load landing on a commit point bypasses the shadow.
   always_comb begin
      frame_wrap_s   = enable && (state_r == DRIVE) && pre_tc_s && (refresh_count == 2'd3);
      commit_now_s   = (state_r == IDLE) || frame_wrap_s;
      next_digits_s  = digits_out;
      next_shadow_s  = shadow_r;
      next_pending_s = pending;
      if (load) begin
         next_shadow_s = digits_in;
         if (commit_now_s) begin
            next_digits_s  = digits_in;
            next_pending_s = 1'b0;
         end else begin
            next_pending_s = 1'b1;
         end
      end else if (commit_now_s && pending) begin
         next_digits_s  = shadow_r;
         next_pending_s = 1'b0;
      end else begin
         next_pending_s = pending;
      end
   end

   // Anode drive decoded from next-cycle state so the registered anodes line
   // up with the registered refresh_count and digits_out.
   always_comb begin
      drive_s      = 1'b0;
      next_anode_s = ANODE_OFF;
      if ((next_state_s == DRIVE) && !(lz_suppress && lz_blanked(next_slot_s, next_digits_s))) begin
         drive_s      = 1'b1;
         next_anode_s = anode_onehot(next_slot_s, ANODE_ACTIVE_LOW);
      end else begin
         drive_s      = 1'b0;
         next_anode_s = ANODE_OFF;
      end
   end

   // FSM state register and slot select.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= IDLE;
         refresh_count <= 2'd0;
      end else begin
         state_r       <= next_state_s;
         refresh_count <= next_slot_s;
      end
   end

   // Digit buffers; reset discards any pending shadow contents.
   always_ff @(posedge clk) begin
      if (reset) begin
         digits_out <= 16'h0000;
         shadow_r   <= 16'h0000;
         pending    <= 1'b0;
      end else begin
         digits_out <= next_digits_s;
         shadow_r   <= next_shadow_s;
         pending    <= next_pending_s;
      end
   end

   // Registered display outputs and frame pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         anode      <= ANODE_OFF;
         blank      <= 1'b1;
         frame_done <= 1'b0;
      end else begin
         anode      <= next_anode_s;
         blank      <= !drive_s;
         frame_done <= frame_wrap_s;
      end
   end

endmodule

// File: doc/ssd_scan_controller.md
Name: ssd_scan_controller

Overview:
- Time-multiplexing scheduler for the 4-digit seven-segment display.
- Generates the 2-bit digit-select (refresh_count) for the downstream digit mux and drives the anode enables.
- Inserts a blanking interval at each digit change to suppress ghosting, and suppresses leading zeros.
- Double-buffers the four BCD digits so new values commit only at frame boundaries, which prevents tearing.

Parameters:
- REFRESH_DIV, 100000: clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range ≥ 2.
- BLANK_CYCLES, 1000: cycles at the start of each slot with all anodes off; legal range 0..REFRESH_DIV-1.
- ANODE_ACTIVE_LOW, 1: 1 means an anode bit of 0 enables its digit; 0 means active-high.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous active-high reset.
- enable, input, 1: 1 scans the display; 0 blanks it.
- lz_suppress, input, 1: 1 enables leading-zero blanking.
- load, input, 1: one-cycle strobe; captures digits_in into the shadow register.
- digits_in, input, 16: {d3,d2,d1,d0}, 4 bits each, d0 = ones.
- digits_out, output, 16: committed digits; feeds the digit mux inputs.
- refresh_count, output, 2: current slot; feeds the mux select.
- anode, output, 4: per-digit enable; bit i drives digit i.
- blank, output, 1: 1 while all anodes are inactive.
- pending, output, 1: shadow holds an uncommitted load.
- frame_done, output, 1: one-cycle pulse at the end of slot 3.

Behaviour:
- Reset state (clk edge with reset=1):
  - prescaler=0, refresh_count=0, digits_out=0, shadow=0, pending=0, frame_done=0.
  - FSM=IDLE, anode all inactive (4'b1111 if active-low), blank=1.
- Prescaler: counts 0..REFRESH_DIV-1 and wraps to 0. The terminal count (TC) is prescaler==REFRESH_DIV-1. Width is clog2(REFRESH_DIV).
- FSM states IDLE, BLANK, DRIVE:
  - IDLE: prescaler and refresh_count held at 0; anodes inactive. Goes to BLANK on the first cycle enable=1.
  - BLANK: anodes inactive, blank=1. Goes to DRIVE when prescaler reaches BLANK_CYCLES-1. If BLANK_CYCLES=0, BLANK is skipped: each slot enters DRIVE directly.
  - DRIVE: anode[refresh_count] active unless suppressed; all other anodes inactive. At TC, refresh_count increments mod 4 (3→0 wraps) and the FSM goes to BLANK, or to DRIVE when BLANK_CYCLES=0.
  - Any state: enable=0 goes to IDLE next cycle, zeroing prescaler and refresh_count.
- Outputs are registered. anode and blank change on the cycle after the state/prescaler condition, with a fixed latency of 1 clk.
- Leading-zero suppression (lz_suppress=1, evaluated on digits_out):
  - digit3 is blanked if d3==0.
  - digit2 is blanked if d3==0 && d2==0.
  - digit1 is blanked if d3, d2 and d1 are all 0.
  - digit0 is never blanked (value 0000 shows "0").
  - A suppressed slot still consumes its full time. blank=1 for that slot.
- Load / commit:
  - load=1 writes digits_in to the shadow and sets pending=1. Back-to-back loads: last write wins.
  - Commit point: TC in slot 3 (frame wrap). At the commit point, if pending, digits_out<=shadow and pending<=0.
  - load coincident with the commit point: digits_in bypasses the shadow straight to digits_out; pending=0.
  - In IDLE, a pending shadow commits on the next cycle. A load in IDLE commits on the cycle after the load.
- frame_done is high for exactly one cycle: the cycle after TC of slot 3. It never pulses in IDLE.
- Reset mid-slot: reset overrides everything on that edge. The shadow is discarded.

Decomposition:
- Shared package ssd_pkg:
  - slot_t (2-bit) and digit_t (4-bit) typedefs.
  - scan_state_t enum {IDLE, BLANK, DRIVE}.
  - NUM_DIGITS=4.
  - Function anode_onehot(slot, active_low).
- Sub-module: ssd_prescaler, a parameterised terminal-count divider with clear and enable inputs, producing count and tc.
- The existing digit mux stays external. This block drives its select and digit inputs.

Test Plan (REFRESH_DIV=8, BLANK_CYCLES=2, ANODE_ACTIVE_LOW=1):
- Scan: reset 2 cycles, then enable=1 -> each slot has 2 cycles anode=1111 followed by 6 cycles of 1110/1101/1011/0111 for slots 0..3; refresh_count 0,1,2,3,0; frame_done pulses every 32 cycles.
- Double buffer: load=1 with digits_in=16'h1234 mid slot 1 -> pending=1 and digits_out unchanged until the cycle after TC of slot 3; then digits_out=16'h1234 and pending=0.
- Coincident load: load with 16'hABCD exactly on slot-3 TC -> digits_out=16'hABCD next cycle, pending=0. Loads of 16'h1111 then 16'h2222 in consecutive cycles -> 16'h2222 commits.
- Leading zeros: lz_suppress=1, digits 16'h0050 -> slots 3 and 2 have anode=1111 and blank=1; slots 1 and 0 drive. With digits 16'h0000 -> only slot 0 drives.
- Disable: enable=0 mid slot 2 -> next cycle anode=1111, refresh_count=0, no frame_done. Re-enable -> restarts at slot 0 in BLANK.
- Reset mid-operation: reset during DRIVE with pending=1 -> all outputs return to reset values; shadow cleared; the next frame shows 16'h0000.
